gcd_engine: RTL and testbench

- Iterative subtraction-based GCD unit for unsigned WIDTH-bit operands.
- Contains the operand registers A/B and the FSM that drives their load/update selection: load from inputs on start, load difference during iteration.
- Sits directly downstream of the operand-load multiplexers.
- Accepts a start pulse with two operands, iterates one subtraction per cycle, returns the result with a one-cycle done pulse.

---
 rtl/gcd_engine.sv | 92 +++++++++
 tb/tb_gcd_engine.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/gcd_engine.sv
// Iterative subtraction GCD: operands load on an accepted start, then one
// larger-minus-smaller step per cycle until they converge or one reaches zero.
module gcd_engine #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] gcd_out,
    output logic [WIDTH-1:0] iter_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] step_q, step_d;
    logic [WIDTH-1:0] gcd_q, gcd_d;
    logic [WIDTH-1:0] iter_q, iter_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            step_q  <= '0;
            gcd_q   <= '0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            step_q  <= step_d;
            gcd_q   <= gcd_d;
            iter_q  <= iter_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        step_d  = step_q;
        gcd_d   = gcd_q;
        iter_d  = iter_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    step_d  = '0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                // A zero operand or equal operands terminate; the nonzero one is the result.
                if (a_q == '0 || b_q == '0 || a_q == b_q) begin
                    gcd_d   = (a_q == '0) ? b_q : a_q;
                    iter_d  = step_q;
                    state_d = ST_DONE;
                end else if (a_q > b_q) begin
                    a_d    = a_q - b_q;
                    step_d = step_q + 1'b1;
                end else begin
                    b_d    = b_q - a_q;
                    step_d = step_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign gcd_out  = gcd_q;
    assign iter_cnt = iter_q;

endmodule

// File: tb/tb_gcd_engine.sv
// Directed bench for gcd_engine: hand-computed results, latencies and
// reset/abort behaviour checked with immediate assertions.
module tb_gcd_engine;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a_in = '0;
    logic [WIDTH-1:0] b_in = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] gcd_out;
    logic [WIDTH-1:0] iter_cnt;

    int tests = 0;
    int fails = 0;

    gcd_engine #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done),
        .gcd_out  (gcd_out),
        .iter_cnt (iter_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called right after the start edge; returns with done high (or on timeout).
    task automatic wait_done(input string tag, input int exp_g, input int exp_i,
                             input int exp_edges, input int bound, input bit hold);
        int               edges;
        bit               busy_ok;
        bit               stable;
        logic [WIDTH-1:0] g0;
        edges   = 0;
        busy_ok = 1'b1;
        stable  = 1'b1;
        g0      = gcd_out;
        chk({tag, "_busy_after_start"}, busy, 1);
        while (!done && edges < bound) begin
            if (hold) begin
                a_in  = WIDTH'($urandom);
                b_in  = WIDTH'($urandom);
                start = 1'b1;
            end
            tick();
            edges++;
            if (!busy) busy_ok = 1'b0;
            if (!done && gcd_out !== g0) stable = 1'b0;
        end
        chk({tag, "_done_seen"}, done, 1);
        chk({tag, "_edges"}, edges, exp_edges);
        chk({tag, "_gcd"}, gcd_out, exp_g);
        chk({tag, "_iter"}, iter_cnt, exp_i);
        chk({tag, "_busy_cont"}, busy_ok, 1);
        chk({tag, "_gcd_stable"}, stable, 1);
    endtask

    task automatic chk_idle(input string tag);
        tick();
        chk({tag, "_done_pulse_end"}, done, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_gcd", gcd_out, 0);
        chk("rst_iter", iter_cnt, 0);
        tick();
        chk("rst_idle_hold", busy, 0);

        start_op(16'd48, 16'd18);
        wait_done("g48_18", 6, 4, 5, 100, 1'b0);
        chk_idle("g48_18");

        start_op(16'd21, 16'd21);
        wait_done("g21_21", 21, 0, 1, 100, 1'b0);
        chk_idle("g21_21");

        start_op(16'd0, 16'd0);
        wait_done("g0_0", 0, 0, 1, 100, 1'b0);
        chk_idle("g0_0");
        start_op(16'd0, 16'd7);
        wait_done("g0_7", 7, 0, 1, 100, 1'b0);
        chk_idle("g0_7");
        start_op(16'd9, 16'd0);
        wait_done("g9_0", 9, 0, 1, 100, 1'b0);
        chk_idle("g9_0");

        start_op(16'd65535, 16'd1);
        wait_done("g65535_1", 1, 65534, 65535, 70000, 1'b0);
        chk_idle("g65535_1");

        // start held high with garbage operands for the whole operation
        start_op(16'd100, 16'd75);
        start = 1'b1;
        wait_done("g100_75", 25, 3, 4, 100, 1'b1);
        a_in  = 16'd8;
        b_in  = 16'd12;
        start = 1'b1;
        tick();
        chk("hold_done_to_idle", busy, 0);
        chk("hold_gcd_kept", gcd_out, 25);
        tick();
        start = 1'b0;
        wait_done("g8_12", 4, 2, 3, 100, 1'b0);
        chk_idle("g8_12");

        // reset aborting an operation mid-calculation
        start_op(16'd48, 16'd18);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_gcd", gcd_out, 0);
        chk("abort_iter", iter_cnt, 0);
        tick();
        chk("abort_stays_idle", busy, 0);
        start_op(16'd10, 16'd4);
        wait_done("g10_4", 2, 3, 4, 100, 1'b0);
        chk_idle("g10_4");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
